// File: rtl/instruction_fetch.sv
// Instruction fetch unit: walks a fetch PC through a combinational instruction
// memory and queues {pc, instruction} pairs for the decoder. Optional macro
// QX1_FETCH_DEEP_QUEUE_EN deepens the queue from 2 to 4 entries.
module instruction_fetch #(
    parameter logic [15:0] RESET_PC = 16'h0000,
    parameter int          PC_STEP  = 2
) (
    input  logic        clk,
    input  logic        rst,
    output logic [15:0] imem_pc,
    input  logic [15:0] imem_instruction,
    input  logic        redirect,
    input  logic [15:0] redirect_pc,
    input  logic        halt,
    output logic        out_valid,
    output logic [15:0] out_instruction,
    output logic [15:0] out_pc,
    input  logic        out_ready,
    output logic        fetch_busy
);

`ifdef QX1_FETCH_DEEP_QUEUE_EN
    localparam int DEPTH = 4;
    localparam int CW    = 3;
`else
    localparam int DEPTH = 2;
    localparam int CW    = 2;
`endif
    localparam int PW = $clog2(DEPTH);
    localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

    typedef enum logic [1:0] {FETCH, FULL, HALTED} state_t;

    state_t          state_reg, state_next;
    logic [15:0]     fetch_pc_reg, fetch_pc_next;
    logic [CW-1:0]   count_reg, count_next;
    logic [PW-1:0]   wr_ptr_reg, wr_ptr_next;
    logic [PW-1:0]   rd_ptr_reg, rd_ptr_next;
    logic            push, pop;
    logic [15:0]     pc_mem    [DEPTH];
    logic [15:0]     instr_mem [DEPTH];
    logic            unused_redirect_lsb;

    // Targets are forced to halfword alignment, so bit 0 is never used.
    assign unused_redirect_lsb = redirect_pc[0];

    assign imem_pc    = fetch_pc_reg;
    assign out_valid  = (count_reg != '0);
    assign fetch_busy = (state_reg == FETCH);

    // A redirect squashes both queue operations on its edge; halt blocks new
    // fetches immediately. A push into a full queue is allowed only alongside a pop.
    assign pop  = out_valid && out_ready && !redirect;
    assign push = (state_reg == FETCH) && !halt && !redirect &&
                  ((count_reg != FULL_COUNT) || pop);

    always_comb begin
        fetch_pc_next = fetch_pc_reg;
        count_next    = count_reg;
        wr_ptr_next   = wr_ptr_reg;
        rd_ptr_next   = rd_ptr_reg;
        if (redirect) begin
            fetch_pc_next = {redirect_pc[15:1], 1'b0};
            count_next    = '0;
            wr_ptr_next   = '0;
            rd_ptr_next   = '0;
        end else begin
            if (push) begin
                fetch_pc_next = fetch_pc_reg + 16'(PC_STEP);
                wr_ptr_next   = wr_ptr_reg + 1'b1;
            end
            if (pop) begin
                rd_ptr_next = rd_ptr_reg + 1'b1;
            end
            case ({push, pop})
                2'b10:   count_next = count_reg + 1'b1;
                2'b01:   count_next = count_reg - 1'b1;
                default: count_next = count_reg;
            endcase
        end
    end

    always_comb begin
        state_next = state_reg;
        if (halt) begin
            state_next = HALTED;
        end else if (redirect) begin
            state_next = FETCH;
        end else begin
            case (state_reg)
                FETCH:   if ((count_next == FULL_COUNT) && !pop) state_next = FULL;
                FULL:    if (pop) state_next = FETCH;
                HALTED:  state_next = FETCH;
                default: state_next = FETCH;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg    <= FETCH;
            fetch_pc_reg <= RESET_PC;
            count_reg    <= '0;
            wr_ptr_reg   <= '0;
            rd_ptr_reg   <= '0;
        end else begin
            state_reg    <= state_next;
            fetch_pc_reg <= fetch_pc_next;
            count_reg    <= count_next;
            wr_ptr_reg   <= wr_ptr_next;
            rd_ptr_reg   <= rd_ptr_next;
        end
    end

    // Queue storage carries no reset; the head outputs are masked by out_valid.
    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
            always_ff @(posedge clk) begin
                if (push && (wr_ptr_reg == PW'(gi))) begin
                    pc_mem[gi]    <= fetch_pc_reg;
                    instr_mem[gi] <= imem_instruction;
                end
            end
        end
    endgenerate

    assign out_pc          = out_valid ? pc_mem[rd_ptr_reg]    : 16'h0000;
    assign out_instruction = out_valid ? instr_mem[rd_ptr_reg] : 16'h0000;

endmodule

// File: doc/instruction_fetch.md
INSTRUCTION_FETCH -- requirements
Module: instruction_fetch

Interface
REQ-001 Parameter RESET_PC, default 16'h0000: fetch address loaded on reset.
REQ-002 Parameter PC_STEP, default 2: byte increment per fetched instruction word.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, asynchronous and active-high.
REQ-005 imem_pc  output  16  address to the combinational instruction memory (pc port).
REQ-006 imem_instruction  input  16  word returned by instruction memory in the same cycle.
REQ-007 redirect  input  1  branch/jump redirect request, one-cycle pulse or level.
REQ-008 redirect_pc  input  16  redirect target address, sampled when redirect=1.
REQ-009 halt  input  1  level; while high, no new fetches.
REQ-010 out_valid  output  1  queue head holds a valid instruction.
REQ-011 out_instruction  output  16  instruction at queue head.
REQ-012 out_pc  output  16  fetch address of the queue head instruction.
REQ-013 out_ready  input  1  consumer accepts head when out_valid=1.
REQ-014 fetch_busy  output  1  high when the FSM is in state FETCH.

Function
REQ-015 The block SHALL drive imem_pc combinationally from the internal fetch_pc register.
REQ-016 The block SHALL buffer {pc, instruction} pairs in a FIFO queue of depth DEPTH (see Configuration).
REQ-017 The FSM SHALL have exactly three states: FETCH, FULL, HALTED.
REQ-018 In FETCH, each edge SHALL push {fetch_pc, imem_instruction} and advance fetch_pc by PC_STEP, modulo 2^16 (16'hFFFE + 2 = 16'h0000).
REQ-019 A pop SHALL occur on an edge where out_valid=1 and out_ready=1; out_valid SHALL equal (count != 0).
REQ-020 A push and a pop in the same edge with count=DEPTH SHALL both occur; count stays DEPTH.
REQ-021 FETCH -> FULL when count reaches DEPTH with no pop; FULL -> FETCH on the edge a pop occurs; FULL performs no push and holds fetch_pc.
REQ-022 Any state -> HALTED when halt=1; HALTED -> FETCH when halt=0; HALTED performs no push, holds fetch_pc, still allows pops.
REQ-023 Redirect SHALL have highest priority: on the edge with redirect=1, count <= 0, fetch_pc <= {redirect_pc[15:1], 1'b0}, any same-edge push and pop SHALL be discarded.
REQ-024 After a redirect edge out_valid SHALL be 0 for one cycle; target instruction SHALL be valid at the following edge unless halt=1.
REQ-025 Redirect while halt=1 SHALL flush and load fetch_pc; state remains HALTED.
REQ-026 out_instruction and out_pc SHALL be 16'h0000 when out_valid=0.
REQ-027 fetch_busy SHALL be 1 only in FETCH.

Reset
REQ-028 rst=1 SHALL immediately set fetch_pc=RESET_PC, count=0, state=FETCH, out_valid=0, out_instruction=0, out_pc=0, fetch_busy=1.
REQ-029 Reset asserted mid-operation SHALL discard all queued entries; first push occurs on the first edge after rst deasserts.

Configuration
REQ-030 Macro QX1_FETCH_DEEP_QUEUE_EN defined: DEPTH=4, count width 3 bits.
REQ-031 Macro QX1_FETCH_DEEP_QUEUE_EN undefined: DEPTH=2, count width 2 bits; all other behaviour identical.

Verification
REQ-032 Release reset, out_ready=1, memory word[n]=16'h1000+n -> out_pc 0,2,4,... with out_instruction 16'h1000,16'h1001,...; one instruction per cycle after first edge.
REQ-033 out_ready=0 for 10 cycles -> FULL after DEPTH edges, fetch_pc=2*DEPTH held, fetch_busy=0; out_ready=1 -> in-order drain, no loss or duplicate.
REQ-034 redirect=1, redirect_pc=16'h0009 while queue full -> next cycle out_valid=0, fetch_pc=16'h0008; following cycle out_pc=16'h0008.
REQ-035 Load fetch_pc=16'hFFFE via redirect -> out_pc 16'hFFFE then 16'h0000.
REQ-036 halt=1 with 2 entries queued, out_ready=1 -> 2 pops then out_valid=0, fetch_pc constant; halt=0 -> fetching resumes at held fetch_pc.
REQ-037 Assert rst between clock edges with queue non-empty -> outputs zero immediately, fetch_pc=RESET_PC, no stale entry after release.
